// File: rtl/obj_line_sched.sv
// obj_line_sched: scanline object scheduler.
// On each line_start the object table is snapshotted, the write bank of a
// ping-pong line bitmap is cleared, and the 6x6 shape ROM rows of every
// object that intersects next_y are ORed into it. The other bank, filled
// during the previous blanking interval, feeds the registered pix_on output.
module obj_line_sched #(
  parameter int N_OBJ    = 4,
  parameter int H_ACTIVE = 640,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                line_start,
  input  logic [YW-1:0]       next_y,
  input  logic [N_OBJ-1:0]    obj_valid,
  input  logic [N_OBJ*XW-1:0] obj_x,
  input  logic [N_OBJ*YW-1:0] obj_y,
  output logic [2:0]          rom_x,
  output logic [2:0]          rom_y,
  output logic                rom_en,
  input  logic                rom_data,
  input  logic [XW-1:0]       pix_x,
  output logic                pix_on,
  output logic                busy,
  output logic                done,
  output logic                overrun
);

  localparam int IW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam int AW = $clog2(H_ACTIVE);
  localparam logic [IW-1:0] LAST_SLOT = IW'(N_OBJ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SCAN,
    S_FETCH,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  // Ping-pong line bitmaps: bank[bank_sel] is written, the other one is read.
  logic                       bank_sel;
  logic [1:0][H_ACTIVE-1:0]   bank;

  // Snapshot of the object table taken at line_start.
  logic [YW-1:0]              snap_ny;
  logic [N_OBJ-1:0]           snap_valid;
  logic [N_OBJ*XW-1:0]        snap_x;
  logic [N_OBJ*YW-1:0]        snap_y;

  logic [IW-1:0]              idx;
  logic [2:0]                 col;
  logic [2:0]                 row;

  // Unpacked views of the snapshot so the current slot is a plain array read.
  logic [XW-1:0]              slot_x [N_OBJ];
  logic [YW-1:0]              slot_y [N_OBJ];

  for (genvar g = 0; g < N_OBJ; g++) begin : g_slot
    assign slot_x[g] = snap_x[g*XW +: XW];
    assign slot_y[g] = snap_y[g*YW +: YW];
  end

  logic [XW-1:0]              cur_x;
  logic [YW-1:0]              cur_y;
  logic [YW:0]                dy;
  logic                       hit;
  logic [XW:0]                px_sum;
  logic                       in_range;
  logic                       last_slot;
  logic                       pix_ok;

  assign cur_x     = slot_x[idx];
  assign cur_y     = slot_y[idx];
  // One extra bit keeps the row offset and column sum free of wrap-around.
  assign dy        = {1'b0, snap_ny} - {1'b0, cur_y};
  assign hit       = snap_valid[idx] && (snap_ny >= cur_y) && (dy <= (YW+1)'(5));
  assign px_sum    = {1'b0, cur_x} + (XW+1)'(col);
  assign in_range  = px_sum < (XW+1)'(H_ACTIVE);
  assign last_slot = (idx == LAST_SLOT);
  assign pix_ok    = {1'b0, pix_x} < (XW+1)'(H_ACTIVE);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking so all flops sample
    // the values from before the edge, independent of statement order.
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a line_start restarts the fetch from any state.
  always_comb begin
    // NOTE: default first, so no path through the case leaves state_nxt
    // unassigned and no latch is inferred.
    state_nxt = state;
    if (line_start) begin
      state_nxt = S_CLEAR;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_IDLE;
        S_CLEAR: state_nxt = S_SCAN;
        S_SCAN: begin
          if (hit) begin
            state_nxt = S_FETCH;
          end else if (last_slot) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_SCAN;
          end
        end
        S_FETCH: begin
          if (col == 3'd5) begin
            state_nxt = last_slot ? S_DONE : S_SCAN;
          end
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Moore outputs: status flags and the ROM address bus.
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    rom_en = 1'b0;
    rom_x  = 3'd0;
    rom_y  = 3'd0;
    case (state)
      S_CLEAR: busy = 1'b1;
      S_SCAN:  busy = 1'b1;
      S_FETCH: begin
        busy   = 1'b1;
        rom_en = 1'b1;
        rom_x  = col;
        rom_y  = row;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: snapshot, slot/column counters, bitmap writes, pixel port.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the bitmaps are flop arrays, not RAM, so they can and must be
      // cleared by reset; pix_on is defined as 0 until a line is fetched.
      bank       <= '0;
      bank_sel   <= 1'b0;
      snap_ny    <= '0;
      snap_valid <= '0;
      snap_x     <= '0;
      snap_y     <= '0;
      idx        <= '0;
      col        <= 3'd0;
      row        <= 3'd0;
      pix_on     <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= line_start && busy;
      pix_on  <= pix_ok ? bank[~bank_sel][pix_x[AW-1:0]] : 1'b0;

      if (line_start) begin
        bank_sel   <= ~bank_sel;
        snap_ny    <= next_y;
        snap_valid <= obj_valid;
        snap_x     <= obj_x;
        snap_y     <= obj_y;
        idx        <= '0;
        col        <= 3'd0;
      end else begin
        case (state)
          S_CLEAR: bank[bank_sel] <= '0;
          S_SCAN: begin
            if (hit) begin
              col <= 3'd0;
              row <= dy[2:0];
            end else if (!last_slot) begin
              idx <= idx + 1'b1;
            end
          end
          S_FETCH: begin
            if (rom_data && in_range) begin
              bank[bank_sel][px_sum[AW-1:0]] <= 1'b1;
            end
            if (col == 3'd5) begin
              col <= 3'd0;
              if (!last_slot) begin
                idx <= idx + 1'b1;
              end
            end else begin
              col <= col + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_obj_line_sched.sv
// Testbench for obj_line_sched: a bench-side shape ROM, a reference model of
// the line bitmap, and queues holding expected fetch lengths and pixel bits.
module tb_obj_line_sched;

  localparam int N_OBJ    = 4;
  localparam int H_ACTIVE = 640;
  localparam int XW       = 10;
  localparam int YW       = 10;

  logic                clk = 1'b0;
  logic                rst;
  logic                line_start;
  logic [YW-1:0]       next_y;
  logic [N_OBJ-1:0]    obj_valid;
  logic [N_OBJ*XW-1:0] obj_x;
  logic [N_OBJ*YW-1:0] obj_y;
  logic [2:0]          rom_x;
  logic [2:0]          rom_y;
  logic                rom_en;
  logic                rom_data;
  logic [XW-1:0]       pix_x;
  logic                pix_on;
  logic                busy;
  logic                done;
  logic                overrun;

  logic [7:0]          rom_tbl [8];
  int                  checks = 0;
  int                  errors = 0;
  int                  ov [N_OBJ];
  int                  ox [N_OBJ];
  int                  oy [N_OBJ];
  logic [H_ACTIVE-1:0] exp_cur = '0;
  logic [H_ACTIVE-1:0] exp_prev = '0;
  int                  lat_q [$];
  int                  fetch_q [$];
  bit                  pix_q [$];

  obj_line_sched #(
    .N_OBJ(N_OBJ), .H_ACTIVE(H_ACTIVE), .XW(XW), .YW(YW)
  ) dut (
    .clk(clk), .rst(rst), .line_start(line_start), .next_y(next_y),
    .obj_valid(obj_valid), .obj_x(obj_x), .obj_y(obj_y),
    .rom_x(rom_x), .rom_y(rom_y), .rom_en(rom_en), .rom_data(rom_data),
    .pix_x(pix_x), .pix_on(pix_on), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Combinational shape ROM; bit c of rom_tbl[r] is column c of row r.
  assign rom_data = rom_en ? rom_tbl[rom_y][rom_x] : 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_obj(input int i, input int v, input int x, input int y);
    ov[i] = v;
    ox[i] = x;
    oy[i] = y;
  endtask

  task automatic clear_objs();
    for (int i = 0; i < N_OBJ; i++) set_obj(i, 0, 0, 0);
  endtask

  // Reference bitmap for scanline ny built from the bench object table.
  function automatic logic [H_ACTIVE-1:0] model(input int ny, output int hits);
    logic [H_ACTIVE-1:0] bm;
    int r;
    bm   = '0;
    hits = 0;
    for (int i = 0; i < N_OBJ; i++) begin
      if (ov[i] != 0 && ny >= oy[i] && ny - oy[i] <= 5) begin
        hits++;
        r = ny - oy[i];
        for (int c = 0; c < 6; c++) begin
          if (rom_tbl[r][c] && ox[i] + c < H_ACTIVE) bm[ox[i] + c] = 1'b1;
        end
      end
    end
    return bm;
  endfunction

  // Pulse line_start for scanline ny, then scramble the live object inputs.
  task automatic start_line(input int ny, input bit exp_ovr);
    int hits;
    for (int i = 0; i < N_OBJ; i++) begin
      obj_valid[i]         = (ov[i] != 0);
      obj_x[i*XW +: XW]    = XW'(ox[i]);
      obj_y[i*YW +: YW]    = YW'(oy[i]);
    end
    next_y   = YW'(ny);
    exp_prev = exp_cur;
    exp_cur  = model(ny, hits);
    lat_q.push_back(2 + N_OBJ + 6 * hits);
    fetch_q.push_back(6 * hits);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    check("overrun", overrun, exp_ovr);
    check("busy_clear", busy, 1);
    obj_valid = N_OBJ'($urandom());
    obj_x     = (N_OBJ*XW)'({$urandom(), $urandom()});
    obj_y     = (N_OBJ*YW)'({$urandom(), $urandom()});
    next_y    = YW'($urandom());
  endtask

  // Count cycles up to and including the done pulse (line_start cycle = 0).
  task automatic wait_done();
    int n;
    int fc;
    n  = 1;
    fc = 0;
    while (!done && n < 200) begin
      tick();
      n++;
      if (rom_en) fc++;
    end
    check("done_latency", n, lat_q.pop_front());
    check("fetch_cycles", fc, fetch_q.pop_front());
    check("busy_in_done", busy, 0);
  endtask

  task automatic wait_fetch();
    int n;
    n = 0;
    while (!rom_en && n < 50) begin
      tick();
      n++;
    end
    check("fetch_reached", rom_en, 1);
  endtask

  // Sweep pix_x over the line plus a few out-of-range columns.
  task automatic sweep(input logic [H_ACTIVE-1:0] bm, input bit idle);
    int p;
    for (int px = 0; px < H_ACTIVE + 4; px++) begin
      p     = (px < H_ACTIVE + 3) ? px : 1023;
      pix_x = XW'(p);
      pix_q.push_back((p < H_ACTIVE) ? bm[p] : 1'b0);
      tick();
      check($sformatf("pix_%0d", p), pix_on, pix_q.pop_front());
      if (idle) begin
        check("idle_busy", busy, 0);
        check("idle_rom_en", rom_en, 0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rom_tbl[0] = 8'b0000_1100;
    rom_tbl[1] = 8'b0010_0001;
    rom_tbl[2] = 8'b0011_1111;
    rom_tbl[3] = 8'b0001_0010;
    rom_tbl[4] = 8'b0010_1101;
    rom_tbl[5] = 8'b0000_1100;
    rom_tbl[6] = 8'b0000_0000;
    rom_tbl[7] = 8'b0000_0000;

    rst        = 1'b1;
    line_start = 1'b0;
    next_y     = '0;
    obj_valid  = '0;
    obj_x      = '0;
    obj_y      = '0;
    pix_x      = '0;
    clear_objs();
    tick();
    tick();
    check("rst_pix_on", pix_on, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_rom_en", rom_en, 0);
    check("rst_rom_x", rom_x, 0);
    check("rst_rom_y", rom_y, 0);
    rst = 1'b0;
    sweep('0, 1'b1);

    // Line A: one object, row 2 (all ones) at x 100..105.
    set_obj(0, 1, 100, 50);
    start_line(52, 1'b0);
    wait_done();

    // Line B, started in the DONE cycle: right-edge clipping.
    clear_objs();
    set_obj(0, 1, 636, 10);
    start_line(10, 1'b0);
    wait_done();
    sweep(exp_prev, 1'b0);

    // Line C: two overlapping objects ORed together.
    clear_objs();
    set_obj(0, 1, 200, 20);
    set_obj(1, 1, 203, 20);
    start_line(25, 1'b0);
    wait_done();
    sweep(exp_prev, 1'b0);

    // Line D: scanline one above the object.
    clear_objs();
    set_obj(0, 1, 30, 50);
    start_line(49, 1'b0);
    wait_done();
    sweep(exp_prev, 1'b0);

    // Line E: scanline one below the object; disabled slot on the line.
    set_obj(2, 0, 10, 56);
    start_line(56, 1'b0);
    wait_done();
    sweep(exp_prev, 1'b0);

    // Line F: every slot hits (worst-case fetch length).
    clear_objs();
    set_obj(0, 1, 0, 300);
    set_obj(1, 1, 634, 296);
    set_obj(2, 1, 320, 297);
    set_obj(3, 1, 322, 295);
    start_line(300, 1'b0);
    wait_done();
    sweep(exp_prev, 1'b0);

    // Line G: no hits; done must be a single-cycle pulse.
    clear_objs();
    start_line(0, 1'b0);
    wait_done();
    tick();
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    sweep(exp_prev, 1'b0);

    // Line H abandoned mid-FETCH by line I.
    set_obj(0, 1, 50, 100);
    start_line(102, 1'b0);
    wait_fetch();
    lat_q.pop_front();
    fetch_q.pop_front();
    clear_objs();
    set_obj(1, 1, 400, 60);
    start_line(61, 1'b1);
    wait_done();
    tick();
    check("overrun_one_cycle", overrun, 0);

    // Line J swaps line I into view.
    clear_objs();
    start_line(0, 1'b0);
    wait_done();
    sweep(exp_prev, 1'b0);

    // Reset mid-FETCH, with a simultaneous line_start that must be ignored.
    set_obj(0, 1, 10, 10);
    start_line(12, 1'b0);
    wait_fetch();
    lat_q.pop_front();
    fetch_q.pop_front();
    rst        = 1'b1;
    line_start = 1'b1;
    tick();
    rst        = 1'b0;
    line_start = 1'b0;
    check("mrst_pix_on", pix_on, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_overrun", overrun, 0);
    check("mrst_rom_en", rom_en, 0);
    check("mrst_rom_x", rom_x, 0);
    check("mrst_rom_y", rom_y, 0);
    tick();
    check("mrst_stays_idle", busy, 0);
    sweep('0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obj_line_sched.md
# obj_line_sched

Scanline scheduler that shares the single 6x6 combinational object-shape ROM (x/y/en/data interface) among up to N_OBJ on-screen objects. On each line start it snapshots the object table, fetches the ROM rows of every object intersecting the next scanline into a ping-pong line bitmap, then serves per-pixel "object on" bits to the pixel mixer during the following active line. It sits between the game-state registers and the VGA pixel pipeline.

## Interface
- N_OBJ, 4: number of object slots (1..8)
- H_ACTIVE, 640: active pixels per line, line-bitmap width
- XW, 10: width of x coordinates
- YW, 10: width of y coordinates

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- line_start  in  1  one-cycle pulse at start of horizontal blank; begins fetch for next line
- next_y  in  YW  scanline number to be fetched, sampled with line_start
- obj_valid  in  N_OBJ  per-slot enable
- obj_x  in  N_OBJ*XW  packed left-edge x, slot i at [i*XW +: XW]
- obj_y  in  N_OBJ*YW  packed top-edge y, slot i at [i*YW +: YW]
- rom_x  out  3  shape ROM column
- rom_y  out  3  shape ROM row
- rom_en  out  1  shape ROM enable
- rom_data  in  1  shape ROM pixel, combinational from rom_x/rom_y/rom_en
- pix_x  in  XW  current active pixel column
- pix_on  out  1  registered object-pixel bit for pix_x
- busy  out  1  high in CLEAR, SCAN, FETCH
- done  out  1  one-cycle pulse when line fetch completes
- overrun  out  1  one-cycle pulse when line_start arrives while busy

## Operation
- Two H_ACTIVE-bit banks; wr_bank filled by fetch, rd_bank read by pixel port; bank select toggles on every accepted line_start.
- On line_start (any state): toggle bank select, latch next_y, obj_valid, obj_x, obj_y into snapshot registers, slot index i=0, go CLEAR. If busy at that edge, pulse overrun and abandon the previous fetch.
- States: IDLE, CLEAR, SCAN, FETCH, DONE.
- CLEAR (1 cycle): zero entire wr_bank; go SCAN.
- SCAN (1 cycle per slot): hit_i = valid_i && next_y >= y_i && (next_y - y_i) <= 5, compare at YW+1 bits, no wrap. Hit -> FETCH with col=0, row=(next_y - y_i)[2:0]. Miss -> i+1, or DONE after slot N_OBJ-1.
- FETCH (6 cycles, col 0..5): rom_en=1, rom_x=col, rom_y=row; if rom_data and (x_i + col) < H_ACTIVE (XW+1-bit sum), set wr_bank[x_i+col]; bits are ORed, overlaps merge, never cleared within the line. After col 5 -> SCAN with i+1, or DONE if i was last.
- DONE (1 cycle): pulse done, go IDLE.
- rom_en=0, rom_x=0, rom_y=0 outside FETCH.
- Pixel port: pix_on <= (pix_x < H_ACTIVE) ? rd_bank[pix_x] : 0, every cycle, regardless of fetch state.

## Timing
- Reset: state IDLE, bank select 0, both banks zero, snapshots zero, pix_on=0, busy=0, done=0, overrun=0, rom_en=0, rom_x=0, rom_y=0.
- line_start sampled at edge T: CLEAR during cycle T+1, SCAN slot 0 at T+2.
- Fetch length = 2 + N_OBJ + 6*hits cycles from line_start to done pulse inclusive; worst case N_OBJ=4: 30 cycles, which must fit in horizontal blank.
- Data written for line L becomes visible on pix_on only after the next line_start (bank swap); pix_on latency 1 cycle from pix_x.
- line_start in DONE cycle: accepted, no overrun, done still pulses.
- rst overrides line_start in the same cycle.
- Object inputs may change freely after the line_start edge; only the snapshot is used.

## Test plan
- Reset then idle -> pix_on=0 for pix_x 0..639, busy=0, rom_en=0 throughout.
- Slot0 valid at (100,50), next_y=52, others invalid -> done 12 cycles after line_start; after next line_start, pix_on at pix_x 100..105 = ROM row 2 (all 1), 99 and 106 = 0.
- Slot0 at (636,10), next_y=10 -> rows clip: bits 638,639 set from ROM row 0 cols 2,3; no write beyond 639, no wrap to column 0.
- Slots 0,1 at (200,20) and (203,20), next_y=25 -> ORed row 5 produces bits 202,203,205,206; done 2+4+12=18 cycles after line_start.
- next_y=49 with object y=50, and next_y=56 with y=50 -> no hit, no FETCH cycles, done at 6 cycles.
- line_start during FETCH -> overrun pulse, wr_bank cleared and fetch restarts from slot 0; rst asserted mid-FETCH -> all outputs return to reset values next cycle.
